// File: rtl/ctrl_pkg.sv
// ctrl_pkg: step indices, default data width and strobe one-hot check shared with the control unit
package ctrl_pkg;
  localparam int STEP_S0 = 0;
  localparam int STEP_S1 = 1;
  localparam int STEP_S2 = 2;
  localparam int STEP_S3 = 3;
  localparam int STEP_S4 = 4;
  localparam int STEP_S5 = 5;
  localparam int DATA_W = 8;
  // True when at most one strobe is high; an idle cycle is legal.
  function automatic logic onehot6(input logic [5:0] s);
    return (s & (s - 6'd1)) == 6'd0;
  endfunction
endpackage

// File: rtl/sat_add.sv
// sat_add: unsigned add that clamps to all-ones and flags the carry
module sat_add #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             sat
);
  logic [WIDTH:0] full;
  always_comb begin
    full = {1'b0, a} + {1'b0, b};
    sat = full[WIDTH];
    sum = sat ? '1 : full[WIDTH-1:0];
  end
endmodule

// File: rtl/accum_datapath.sv
// accum_datapath: strobe-sequenced sample / saturating add / bias subtract / publish datapath
module accum_datapath
  import ctrl_pkg::*;
#(
  parameter int               WIDTH  = DATA_W,
  parameter int               PASSES = 4,
  parameter logic [WIDTH-1:0] BIAS   = '0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             S0,
  input  logic             S1,
  input  logic             S2,
  input  logic             S3,
  input  logic             S4,
  input  logic             S5,
  input  logic [WIDTH-1:0] DIN,
  output logic [WIDTH-1:0] DOUT,
  output logic             CLR,
  output logic             OVERFLOW,
  output logic             DONE,
  output logic             ONEHOT_ERR
);
  logic [WIDTH-1:0] a, acc, sum;
  logic [7:0] cnt;
  logic [5:0] s, sel;
  logic sat;
  sat_add #(.WIDTH(WIDTH)) u_add (.a(acc), .b(a), .sum(sum), .sat(sat));
  // Isolate the lowest set strobe so conflicting strobes resolve by priority.
  always_comb begin
    s = {S5, S4, S3, S2, S1, S0};
    sel = s & (~s + 6'd1);
    CLR = cnt == 8'd1;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      a <= '0;
      acc <= '0;
      cnt <= 8'(PASSES);
      DOUT <= '0;
      OVERFLOW <= 1'b0;
      DONE <= 1'b0;
      ONEHOT_ERR <= 1'b0;
    end else begin
      DONE <= 1'b0;
      if (!onehot6(s)) ONEHOT_ERR <= 1'b1;
      if (sel[STEP_S0]) begin
        a <= '0;
        acc <= '0;
        cnt <= 8'(PASSES);
        OVERFLOW <= 1'b0;
      end else if (sel[STEP_S1]) begin
        a <= DIN;
      end else if (sel[STEP_S2]) begin
        acc <= sum;
        if (sat) OVERFLOW <= 1'b1;
        if (cnt == 8'd0) ONEHOT_ERR <= 1'b1;
        else cnt <= cnt - 8'd1;
      end else if (sel[STEP_S3]) begin
        acc <= (acc >= BIAS) ? acc - BIAS : '0;
      end else if (sel[STEP_S4]) begin
        DOUT <= acc;
      end else if (sel[STEP_S5]) begin
        DOUT <= acc;
        if (cnt == 8'd0) begin
          DONE <= 1'b1;
          cnt <= 8'(PASSES);
        end
      end
    end
  end
endmodule
